stopwatch_time_counter: RTL
===========================

# stopwatch_time_counter

Consumes the one-cycle 10 Hz enable pulse (`pulse10Hz`) from the stopwatch's 5 MHz pulse generator and keeps elapsed time as four BCD digits, M:SS.t (tenths, seconds units, seconds tens, minutes). A start/stop/clear/lap control FSM gates counting and drives a lap-hold display snapshot. Outputs feed the 7-segment display multiplexer directly.

## Interface
- `MIN_MAX`, default 9: highest minutes digit value, legal range 1..9. The count wraps after MIN_MAX:59.9.
- `clk5`  in  1  5 MHz system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (0) immediately forces the reset state; deassertion is synchronous to clk5 upstream.
- `pulse10Hz`  in  1  count enable, high for exactly one clk5 cycle every 0.1 s.
- `startStop`  in  1  debounced one-cycle pulse; toggles run/stop.
- `clear`  in  1  debounced one-cycle pulse; zeros everything.
- `lap`  in  1  debounced one-cycle pulse; toggles display hold while running.
- `tenths`  out  4  displayed tenths digit, BCD 0..9.
- `secOnes`  out  4  displayed seconds units digit, BCD 0..9.
- `secTens`  out  4  displayed seconds tens digit, BCD 0..5.
- `minutes`  out  4  displayed minutes digit, BCD 0..MIN_MAX.
- `running`  out  1  high in the RUNNING state.
- `lapHeld`  out  1  high while the display is frozen on a lap snapshot.
- `overflow`  out  1  sticky; set on wrap past MIN_MAX:59.9.

## Operation
- FSM states: IDLE (count zero, never started), RUNNING, STOPPED.
  - IDLE + startStop → RUNNING.
  - RUNNING + startStop → STOPPED.
  - STOPPED + startStop → RUNNING. The count resumes; it is not zeroed.
  - Any state + clear → IDLE.
- Priority within one cycle: clear > startStop > lap.
- Live count is four BCD registers, incremented by one tenth on each clk5 edge where state == RUNNING and pulse10Hz == 1.
- Ripple rules, all in the same edge:
  - tenths 9→0 carries into secOnes.
  - secOnes 9→0 carries into secTens.
  - secTens 5→0 carries into minutes.
  - minutes MIN_MAX→0 sets `overflow`.
- Wrap: MIN_MAX:59.9 + tick → 0:00.0 with `overflow`=1. Counting continues. `overflow` clears only on clear or reset.
- Non-BCD values never appear on any digit.
- Lap:
  - In RUNNING with lapHeld=0, lap copies the live count into the snapshot registers and sets lapHeld.
  - In RUNNING with lapHeld=1, lap clears lapHeld.
  - In IDLE or STOPPED, lap is ignored.
  - lapHeld survives stop/start and is cleared by clear.
- Display outputs show the snapshot when lapHeld=1, the live count otherwise.
- Clear zeros the live count and snapshot, and clears lapHeld and overflow.
- Reset: state IDLE; all digits 0; running, lapHeld and overflow all 0.

## Timing
- All outputs are registered (or a mux of registers selected by lapHeld). No combinational path from inputs to outputs.
- A tick accepted at edge N is visible on the digit outputs after edge N; display latency is 1 cycle from the pulse10Hz-high cycle.
- startStop at edge N: `running` changes after edge N.
- A pulse10Hz coincident with a start (state not yet RUNNING at that edge) is not counted.
- A pulse10Hz coincident with a stop (state still RUNNING at that edge) is counted.
- clear coincident with pulse10Hz: result is 0:00.0, IDLE, overflow=0. The tick is discarded.
- lap coincident with pulse10Hz in RUNNING: the snapshot captures the pre-increment count.
- Asserting reset mid-count forces the reset state within the same cycle, independent of clk5.
- Inputs held high for more than one cycle are treated as one event per high cycle. Callers guarantee single-cycle pulses.

## Test plan
- Reset then start, apply 10 pulses spaced 5 cycles apart → 0:01.0, running=1. Each digit changes exactly 1 cycle after its pulse.
- Preload via ticks to 0:59.9, one more pulse → 1:00.0. With MIN_MAX=9 at 9:59.9, one pulse → 0:00.0, overflow=1. Further pulses keep counting with overflow still 1.
- Run to 0:03.4, stop with a coincident pulse → 0:03.5, STOPPED. 20 further pulses → no change. Start → resumes from 0:03.5.
- Run, lap at 0:02.1 → display frozen at 0:02.1 and lapHeld=1 while ticks continue to 0:04.0. Second lap → display shows 0:04.0. lap in STOPPED → no effect.
- clear, startStop and pulse10Hz in the same cycle while RUNNING at 0:07.7 → 0:00.0, IDLE, running=0, overflow=0, lapHeld=0.
- Assert reset asynchronously between clk5 edges mid-run → all outputs 0 before the next edge. After release, pulses are ignored until startStop.

Source files
------------

// File: rtl/stopwatch_time_counter_if.sv
// Control pulses into, and display digits/status out of, the stopwatch time counter.
// master drives the control pulses; slave is the counter that drives the display side.
interface stopwatch_time_counter_if;
  logic       pulse10Hz;
  logic       startStop;
  logic       clear;
  logic       lap;
  logic [3:0] tenths;
  logic [3:0] secOnes;
  logic [3:0] secTens;
  logic [3:0] minutes;
  logic       running;
  logic       lapHeld;
  logic       overflow;

  modport master (
    output pulse10Hz, startStop, clear, lap,
    input  tenths, secOnes, secTens, minutes, running, lapHeld, overflow
  );

  modport slave (
    input  pulse10Hz, startStop, clear, lap,
    output tenths, secOnes, secTens, minutes, running, lapHeld, overflow
  );
endinterface

// File: rtl/stopwatch_time_counter.sv
// M:SS.t BCD stopwatch counter with run/stop/clear/lap control and lap-hold display snapshot.
// Latency: 1 clk5 from an accepted tick or control pulse to the outputs; no backpressure, inputs are one-cycle pulses.
module stopwatch_time_counter #(
  parameter int MIN_MAX = 9
) (
  input  logic                    clk5,
  input  logic                    reset,
  stopwatch_time_counter_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] minutes;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
  } bcd_t;

  localparam logic [3:0] MIN_LAST = MIN_MAX[3:0];

  state_t state;
  bcd_t   live;
  bcd_t   snap;
  bcd_t   live_inc;
  logic   wrap;
  logic   running;
  logic   lap_held;
  logic   overflow;

  // One-tenth increment with full ripple; wrap flags the MIN_MAX:59.9 -> 0:00.0 rollover.
  always_comb begin
    live_inc = live;
    wrap     = 1'b0;
    if (live.tenths != 4'd9) begin
      live_inc.tenths = live.tenths + 4'd1;
    end else begin
      live_inc.tenths = 4'd0;
      if (live.sec_ones != 4'd9) begin
        live_inc.sec_ones = live.sec_ones + 4'd1;
      end else begin
        live_inc.sec_ones = 4'd0;
        if (live.sec_tens != 4'd5) begin
          live_inc.sec_tens = live.sec_tens + 4'd1;
        end else begin
          live_inc.sec_tens = 4'd0;
          if (live.minutes != MIN_LAST) begin
            live_inc.minutes = live.minutes + 4'd1;
          end else begin
            live_inc.minutes = 4'd0;
            wrap             = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      live     <= '0;
      snap     <= '0;
      running  <= 1'b0;
      lap_held <= 1'b0;
      overflow <= 1'b0;
    end else if (sw.clear) begin
      // clear outranks everything, including a coincident tick
      state    <= IDLE;
      live     <= '0;
      snap     <= '0;
      running  <= 1'b0;
      lap_held <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Tick gated by the current state, so a start edge drops its tick and a stop edge keeps it.
      if (state == RUNNING && sw.pulse10Hz) begin
        live <= live_inc;
        if (wrap) overflow <= 1'b1;
      end

      if (sw.startStop) begin
        case (state)
          IDLE, STOPPED: begin
            state   <= RUNNING;
            running <= 1'b1;
          end
          RUNNING: begin
            state   <= STOPPED;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end else if (sw.lap && state == RUNNING) begin
        if (!lap_held) begin
          snap     <= live;
          lap_held <= 1'b1;
        end else begin
          lap_held <= 1'b0;
        end
      end
    end
  end

  assign sw.tenths   = lap_held ? snap.tenths   : live.tenths;
  assign sw.secOnes  = lap_held ? snap.sec_ones : live.sec_ones;
  assign sw.secTens  = lap_held ? snap.sec_tens : live.sec_tens;
  assign sw.minutes  = lap_held ? snap.minutes  : live.minutes;
  assign sw.running  = running;
  assign sw.lapHeld  = lap_held;
  assign sw.overflow = overflow;

endmodule
